// File: rtl/mesh_term_fifo.sv
// Per-terminal ingress FIFO feeding one mesh router port: show-ahead head packet,
// occupancy, overflow/underflow pulses, saturating drop counter and broadcast flag.
module mesh_term_fifo #(
    parameter int          pckg_sz    = 40,
    parameter int          fifo_depth = 4,
    parameter logic [7:0]  broadcast  = 8'hFF,
    parameter int          cnt_w      = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [pckg_sz-1:0]                data_in,
    output logic                              full,
    output logic                              pndng,
    output logic [pckg_sz-1:0]                data_out_i_in,
    input  logic                              pop,
    output logic                              head_is_bcast,
    output logic [$clog2(fifo_depth+1)-1:0]   count,
    output logic                              overflow,
    output logic                              underflow,
    output logic [cnt_w-1:0]                  drop_cnt
);

    localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int OCC_W = $clog2(fifo_depth + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(fifo_depth - 1);
    localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(fifo_depth);

    logic [pckg_sz-1:0] mem [fifo_depth];
    logic [PTR_W-1:0]   rd_ptr_p0;
    logic [PTR_W-1:0]   wr_ptr_p0;
    logic [OCC_W-1:0]   count_p0;
    logic [cnt_w-1:0]   drop_p0;
    logic               ovf_p0;
    logic               udf_p0;

    logic is_full;
    logic is_empty;
    logic wr_en;
    logic rd_en;

    // Pointers wrap explicitly so any depth works, not just powers of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [cnt_w-1:0] sat_inc(input logic [cnt_w-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        is_full  = (count_p0 == DEPTH);
        is_empty = (count_p0 == '0);
        // A pop frees the slot in the same edge, so a push at full still lands.
        wr_en    = push && (!is_full || pop);
        rd_en    = pop && !is_empty;
    end

    // ---- storage: data only, no reset; stale entries are hidden by count ----
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_p0] <= data_in;
    end

    // ---- control state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_p0 <= '0;
            wr_ptr_p0 <= '0;
            count_p0  <= '0;
            drop_p0   <= '0;
            ovf_p0    <= 1'b0;
            udf_p0    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_p0 <= ptr_inc(wr_ptr_p0);
            if (rd_en) rd_ptr_p0 <= ptr_inc(rd_ptr_p0);
            unique case ({wr_en, rd_en})
                2'b10:   count_p0 <= count_p0 + 1'b1;
                2'b01:   count_p0 <= count_p0 - 1'b1;
                default: count_p0 <= count_p0;
            endcase
            ovf_p0 <= push && is_full && !pop;
            udf_p0 <= pop && is_empty;
            if (push && is_full && !pop) drop_p0 <= sat_inc(drop_p0);
        end
    end

    always_comb begin
        full          = is_full;
        pndng         = !is_empty;
        data_out_i_in = pndng ? mem[rd_ptr_p0] : '0;
        head_is_bcast = pndng && (data_out_i_in[pckg_sz-1 -: 8] == broadcast);
        count         = count_p0;
        overflow      = ovf_p0;
        underflow     = udf_p0;
        drop_cnt      = drop_p0;
    end

endmodule

// File: doc/mesh_term_fifo.md
# mesh_term_fifo

Per-terminal ingress buffer between the verification driver (or a host source) and one terminal of the 4x4 mesh router. Accepts packets of `pckg_sz` bits on a push interface and presents them to the router through the router's `pndng` / `pop` / `data_out_i_in` handshake in FIFO order. It also reports:
- occupancy and overflow/underflow events;
- a saturating drop counter;
- a broadcast flag for the head packet, so the monitor and scoreboard can correlate injected traffic.

## Interface
- `pckg_sz`, 40: packet width in bits.
  - Bits `[pckg_sz-1:pckg_sz-8]` hold the destination/next-jump byte.
- `fifo_depth`, 4: number of packet entries. Any integer ≥ 2; need not be a power of two.
- `broadcast`, 8'hFF: destination byte value that marks a broadcast packet.
- `cnt_w`, 8: width of the drop counter.

Ports:
- `clk` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: synchronous reset, active-high.
- `push` input 1: write request from the driver side.
- `data_in` input `pckg_sz`: packet to write, sampled when `push`=1.
- `full` output 1: FIFO holds `fifo_depth` entries.
- `pndng` output 1: FIFO non-empty; the head packet is valid.
- `data_out_i_in` output `pckg_sz`: head packet (show-ahead). Equals 0 when empty.
- `pop` input 1: router consumes the head packet at this edge.
- `head_is_bcast` output 1: `pndng` && `data_out_i_in[pckg_sz-1:pckg_sz-8]` == `broadcast`.
- `count` output `$clog2(fifo_depth+1)`: current occupancy.
- `overflow` output 1: one-cycle pulse; a push was dropped.
- `underflow` output 1: one-cycle pulse; a pop arrived while empty.
- `drop_cnt` output `cnt_w`: saturating count of dropped pushes.

## Operation
- Storage is a circular buffer of `fifo_depth` entries with read and write pointers. Pointers wrap from `fifo_depth-1` to 0, with no power-of-two assumption.
- Write and read are evaluated in the same edge using pre-edge state.
- **Push, not full:** the entry is written at the write pointer, the write pointer advances, and `count` is incremented.
- **Push while full:**
  - Without a same-cycle pop: `data_in` is discarded, storage is unchanged, `overflow`=1 next cycle, and `drop_cnt` is incremented, saturating at 2^`cnt_w`-1.
  - With a same-cycle pop: both operations take effect and `count` stays `fifo_depth`. No overflow.
- **Pop while non-empty:** the read pointer advances and `count` is decremented.
- **Pop while empty:**
  - Ignored, with `underflow`=1 next cycle.
  - A simultaneous push still writes, so `count` becomes 1.
  - Data never bypasses: a packet pushed into an empty FIFO is first visible one cycle later.
- **Simultaneous push+pop, 0 < count < fifo_depth:** both take effect and `count` is unchanged.
- `data_out_i_in` is driven from the entry at the read pointer, registered or muxed. It must equal the oldest stored packet whenever `pndng`=1, and is forced to 0 when empty.
- `full`, `pndng` and `count` are derived from registered state and change only on clock edges.
- **Reset:** takes priority over push and pop in the same cycle. It clears pointers, `count`, `drop_cnt`, `overflow` and `underflow`. Reset mid-operation discards all stored packets. Storage contents need not be cleared, but `data_out_i_in` must read 0.

## Timing
- Reset values: `full`=0, `pndng`=0, `data_out_i_in`=0, `head_is_bcast`=0, `count`=0, `overflow`=0, `underflow`=0, `drop_cnt`=0.
- Push-to-visible latency is 1 cycle. For a push at edge N into an empty FIFO, `pndng`=1 and the packet is on `data_out_i_in` after edge N.
- Pop-to-next-head latency is 1 cycle. After the pop edge, the next entry (or 0 if empty) is presented.
- The router may hold `pop`=1 continuously. One packet is consumed per cycle while `pndng`=1.
- `overflow` and `underflow` are high for exactly one cycle per offending edge. They are high on consecutive cycles when the offences are consecutive.
- Sustained throughput is one push and one pop per cycle at any occupancy.

## Test plan
- **Reset/empty:** hold `reset` 2 cycles, then idle. Required: all outputs 0. Then pop with no data: `underflow` pulses 1 cycle, `count` stays 0.
- **Ordering:** push 0xAA00000001, 0xAA00000002, 0xAA00000003 on consecutive cycles. Required: `count`=3. Then pop 3 times: `data_out_i_in` shows 0x..01, 0x..02, 0x..03 in order, then `pndng`=0 and the output is 0.
- **Full/overflow:** push 6 packets with no pop at `fifo_depth`=4. Required: `full`=1 after the 4th push; `overflow` pulses on the 5th and 6th; `drop_cnt`=2. A subsequent drain returns only the first 4 packets.
- **Simultaneous at full:** with the FIFO full, push 0x11 and pop in the same cycle. Required: `count`=4, no overflow, old head removed, 0x11 emerges last. Repeat for 10 cycles: wrap-around keeps order.
- **Broadcast flag:** push 0xFF12345678, then 0x0312345678. Required: `head_is_bcast`=1 while the first is the head; 0 after pop.
- **Reset mid-operation:** with 3 entries and `push`=1 in the reset cycle. Required: after reset, `count`=0, `pndng`=0, `drop_cnt`=0; the pushed packet is not stored.
